reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Consumes the synchronised system reset and distributes staged, ordered reset releases to the Bit Error Tester sub-domains: core control, PRBS transmitter, PRBS receiver/checker.
- Holds every domain in reset until the clock PLL reports lock, then releases core, TX and RX in that order, STAGE_CYCLES apart.
- Re-enters the sequence on loss of lock or a debounced push-button reset, and counts re-entries for the status display.

Parameters:
- DEBOUNCE_CYCLES, 1000, consecutive stable clk cycles required before the synchronised button level is accepted.
- STAGE_CYCLES, 16, clk cycles between successive reset releases (>=1).
- BTN_ACTIVE_LOW, 1, 1 = btn_reset pressed when 0; 0 = pressed when 1.

Ports:
- clk  input  1  system clock.
- async_reset  input  1  asynchronous, active-high reset; driven from the synchronised system reset.
- pll_locked  input  1  PLL lock flag, asynchronous to clk.
- btn_reset  input  1  raw push-button, asynchronous, bouncing.
- rst_core  output  1  active-high reset, core control domain.
- rst_tx  output  1  active-high reset, PRBS generator.
- rst_rx  output  1  active-high reset, PRBS checker and error counter.
- reset_done  output  1  high when all domains are released.
- reset_events  output  8  saturating count of re-entries from RUN.

Behaviour:
- All outputs are registered.
- During async_reset:
  - rst_core = rst_tx = rst_rx = 1; reset_done = 0; reset_events = 0.
  - State = WAIT_LOCK; stage counter = 0.
  - Sync flops = 0; debounced button = not pressed.
- pll_locked passes through a 2-flop synchroniser to give lock_s.
- btn_reset passes through a 2-flop synchroniser, then is normalised to the pressed polarity using BTN_ACTIVE_LOW.
- Debounce:
  - A counter increments each cycle the synchronised level differs from btn_db, and clears to 0 on any cycle it matches.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, btn_db takes the new level on the next edge and the counter clears.
- abort = (lock_s == 0) or (btn_db == pressed).
- States: WAIT_LOCK, HOLD_ALL, REL_CORE, REL_TX, RUN.
  - WAIT_LOCK:
    - All resets = 1; reset_done = 0; counter = 0.
    - When abort = 0, go to HOLD_ALL.
  - HOLD_ALL:
    - All resets = 1.
    - Counter increments each cycle.
    - When counter == STAGE_CYCLES-1: go to REL_CORE, rst_core <= 0, counter <= 0.
  - REL_CORE:
    - Same counting rule.
    - On exit: go to REL_TX, rst_tx <= 0.
  - REL_TX:
    - Same counting rule.
    - On exit: go to RUN, rst_rx <= 0, reset_done <= 1.
  - RUN: hold all outputs.
- Release timing, with edge 0 as the first edge sampling pll_locked = 1 (button idle, no abort):
  - lock_s = 1 after edge 1; state = HOLD_ALL after edge 2.
  - rst_core = 0 after edge 2+STAGE_CYCLES.
  - rst_tx = 0 after edge 2+2*STAGE_CYCLES.
  - rst_rx = 0 and reset_done = 1 after edge 2+3*STAGE_CYCLES.
- Abort priority: abort = 1 in any state other than WAIT_LOCK overrides the stage transitions. On the next edge:
  - state = WAIT_LOCK; all resets = 1; reset_done = 0; counter = 0.
- reset_events increments by 1 only on aborts taken from RUN, and saturates at 255.
- Button held pressed keeps the block in WAIT_LOCK. The sequence restarts only after btn_db returns to not pressed and lock_s = 1.
- Reset order is invariant: rst_tx never 0 while rst_core = 1; rst_rx never 0 while rst_tx = 1.
- Reasserting async_reset mid-sequence forces the reset values immediately, without waiting for a clock edge.

Test Plan:
- STAGE_CYCLES = 4, DEBOUNCE_CYCLES = 8, button idle; release async_reset, assert pll_locked before edge 0 -> rst_core falls after edge 6, rst_tx after edge 10, rst_rx and reset_done after edge 14; reset_events = 0.
- In RUN, drop pll_locked for 5 cycles -> all resets high 3 edges after the drop; reset_events = 1. Restore lock -> full release sequence repeats with the same 4-cycle spacing.
- In RUN, bounce btn_reset (BTN_ACTIVE_LOW = 1) low/high in 3-cycle bursts for 30 cycles, then hold low 8+ cycles -> no abort during the bursts. Abort occurs 2+8+1 edges after the stable low begins; sequence held until release is debounced.
- Drop pll_locked during REL_CORE (rst_core = 0, rst_tx = 1) -> rst_core returns to 1, state WAIT_LOCK, reset_events unchanged; ordering invariant holds throughout.
- Force 256 lock-loss aborts from RUN -> reset_events saturates at 255, no wrap to 0.
- Assert async_reset asynchronously while in REL_TX -> rst_core/tx/rx = 1, reset_done = 0 and reset_events = 0 before the next clk edge.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged reset release (core -> tx -> rx, STAGE_CYCLES apart) once the PLL is locked and the button is idle.
// All outputs registered; no handshake: lock loss or a debounced button press re-enters the sequence on the next edge.
module reset_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int STAGE_CYCLES    = 16,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       async_reset,
  input  logic       pll_locked,
  input  logic       btn_reset,
  output logic       rst_core,
  output logic       rst_tx,
  output logic       rst_rx,
  output logic       reset_done,
  output logic [7:0] reset_events
);

  localparam int SW = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SW-1:0] STAGE_LAST = SW'(STAGE_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    HOLD_ALL,
    REL_CORE,
    REL_TX,
    RUN
  } state_t;

  state_t          state;
  logic [SW-1:0]   stage_cnt;
  logic [DW-1:0]   db_cnt;
  logic            lock_meta, lock_s;
  logic            btn_meta, btn_sync;
  logic            btn_pressed_s;
  logic            btn_db;
  logic            abort;

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      btn_meta  <= 1'b0;
      btn_sync  <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
      btn_meta  <= btn_reset;
      btn_sync  <= btn_meta;
    end
  end

  assign btn_pressed_s = BTN_ACTIVE_LOW ? ~btn_sync : btn_sync;

  // btn_db only follows the synchronised level after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_pressed_s != btn_db) begin
      if (db_cnt == DB_LAST) begin
        btn_db <= btn_pressed_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign abort = ~lock_s | btn_db;

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state        <= WAIT_LOCK;
      stage_cnt    <= '0;
      rst_core     <= 1'b1;
      rst_tx       <= 1'b1;
      rst_rx       <= 1'b1;
      reset_done   <= 1'b0;
      reset_events <= 8'd0;
    end else if (abort && state != WAIT_LOCK) begin
      // Abort wins over any stage transition due on the same edge.
      state      <= WAIT_LOCK;
      stage_cnt  <= '0;
      rst_core   <= 1'b1;
      rst_tx     <= 1'b1;
      rst_rx     <= 1'b1;
      reset_done <= 1'b0;
      if (state == RUN && reset_events != 8'hFF) begin
        reset_events <= reset_events + 8'd1;
      end
    end else begin
      case (state)
        WAIT_LOCK: begin
          rst_core   <= 1'b1;
          rst_tx     <= 1'b1;
          rst_rx     <= 1'b1;
          reset_done <= 1'b0;
          stage_cnt  <= '0;
          if (!abort) begin
            state <= HOLD_ALL;
          end
        end
        HOLD_ALL: begin
          if (stage_cnt == STAGE_LAST) begin
            stage_cnt <= '0;
            rst_core  <= 1'b0;
            state     <= REL_CORE;
          end else begin
            stage_cnt <= stage_cnt + SW'(1);
          end
        end
        REL_CORE: begin
          if (stage_cnt == STAGE_LAST) begin
            stage_cnt <= '0;
            rst_tx    <= 1'b0;
            state     <= REL_TX;
          end else begin
            stage_cnt <= stage_cnt + SW'(1);
          end
        end
        REL_TX: begin
          if (stage_cnt == STAGE_LAST) begin
            stage_cnt  <= '0;
            rst_rx     <= 1'b0;
            reset_done <= 1'b1;
            state      <= RUN;
          end else begin
            stage_cnt <= stage_cnt + SW'(1);
          end
        end
        RUN: begin
        end
        default: begin
          state <= WAIT_LOCK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with STAGE_CYCLES=4, DEBOUNCE_CYCLES=8, active-low button.
module tb_reset_sequencer;

  localparam int S = 4;
  localparam int D = 8;

  logic       clk;
  logic       async_reset;
  logic       pll_locked;
  logic       btn_reset;
  logic       rst_core, rst_tx, rst_rx, reset_done;
  logic [7:0] reset_events;

  int n_checks = 0;
  int n_fail   = 0;

  reset_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .STAGE_CYCLES(S),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .async_reset(async_reset),
    .pll_locked(pll_locked),
    .btn_reset(btn_reset),
    .rst_core(rst_core),
    .rst_tx(rst_tx),
    .rst_rx(rst_rx),
    .reset_done(reset_done),
    .reset_events(reset_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Release order must hold on every cycle outside reset.
  always @(negedge clk) begin
    if (!async_reset) begin
      n_checks++;
      if ((!rst_tx && rst_core) || (!rst_rx && rst_tx)) begin
        n_fail++;
        $display("FAIL order_invariant t=%0t: core=%b tx=%b rx=%b", $time, rst_core, rst_tx, rst_rx);
      end
    end
  end

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    async_reset = 1'b1;
    pll_locked  = 1'b0;
    btn_reset   = 1'b1;
    step(3);
    n_checks++;
    if ({rst_core, rst_tx, rst_rx, reset_done} !== 4'b1110 || reset_events !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: got core/tx/rx/done=%b%b%b%b ev=%0d, want 1110 ev=0",
               rst_core, rst_tx, rst_rx, reset_done, reset_events);
    end
    async_reset = 1'b0;
    step(6);
    n_checks++;
    if ({rst_core, rst_tx, rst_rx, reset_done} !== 4'b1110) begin
      n_fail++;
      $display("FAIL wait_lock_hold: got %b%b%b%b, want 1110", rst_core, rst_tx, rst_rx, reset_done);
    end
  endtask

  // Raises lock so the next edge is edge 0, then checks every edge through RUN.
  task automatic test_release_sequence(input string tag, input logic [7:0] exp_ev);
    logic e_core, e_tx, e_rx, e_done;
    pll_locked = 1'b1;
    for (int e = 0; e <= 2 + 3 * S; e++) begin
      step(1);
      e_core = (e < 2 + S);
      e_tx   = (e < 2 + 2 * S);
      e_rx   = (e < 2 + 3 * S);
      e_done = !e_rx;
      n_checks++;
      if ({rst_core, rst_tx, rst_rx, reset_done} !== {e_core, e_tx, e_rx, e_done}) begin
        n_fail++;
        $display("FAIL %s edge %0d: got core/tx/rx/done=%b%b%b%b, want %b%b%b%b", tag, e,
                 rst_core, rst_tx, rst_rx, reset_done, e_core, e_tx, e_rx, e_done);
      end
    end
    n_checks++;
    if (reset_events !== exp_ev) begin
      n_fail++;
      $display("FAIL %s events: got %0d, want %0d", tag, reset_events, exp_ev);
    end
  endtask

  task automatic test_lock_loss();
    pll_locked = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step(1);
      n_checks++;
      if (e < 3 && (rst_core !== 1'b0 || reset_done !== 1'b1)) begin
        n_fail++;
        $display("FAIL lock_loss_early edge %0d: got core=%b done=%b, want 0 1", e, rst_core, reset_done);
      end else if (e == 3 && ({rst_core, rst_tx, rst_rx, reset_done} !== 4'b1110 || reset_events !== 8'd1)) begin
        n_fail++;
        $display("FAIL lock_loss_abort: got %b%b%b%b ev=%0d, want 1110 ev=1",
                 rst_core, rst_tx, rst_rx, reset_done, reset_events);
      end
    end
    step(2);
    test_release_sequence("relock", 8'd1);
  endtask

  task automatic test_button_bounce();
    for (int i = 0; i < 30; i++) begin
      btn_reset = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      step(1);
      n_checks++;
      if (rst_core !== 1'b0 || reset_done !== 1'b1) begin
        n_fail++;
        $display("FAIL bounce_no_abort cycle %0d: got core=%b done=%b, want 0 1", i, rst_core, reset_done);
      end
    end
    btn_reset = 1'b0;
    step(2 + D);
    n_checks++;
    if (reset_done !== 1'b1) begin
      n_fail++;
      $display("FAIL btn_before_abort: got done=%b, want 1", reset_done);
    end
    step(1);
    n_checks++;
    if ({rst_core, rst_tx, rst_rx, reset_done} !== 4'b1110 || reset_events !== 8'd2) begin
      n_fail++;
      $display("FAIL btn_abort: got %b%b%b%b ev=%0d, want 1110 ev=2",
               rst_core, rst_tx, rst_rx, reset_done, reset_events);
    end
    step(20);
    n_checks++;
    if (rst_core !== 1'b1) begin
      n_fail++;
      $display("FAIL btn_held: got core=%b, want 1", rst_core);
    end
    // Release is debounced after edge 2+D, sequence starts on the following edge.
    btn_reset = 1'b1;
    step(3 + D + S - 1);
    n_checks++;
    if (rst_core !== 1'b1) begin
      n_fail++;
      $display("FAIL btn_release_early: got core=%b, want 1", rst_core);
    end
    step(1);
    n_checks++;
    if (rst_core !== 1'b0 || rst_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL btn_release_core: got core=%b tx=%b, want 0 1", rst_core, rst_tx);
    end
    step(2 * S);
    n_checks++;
    if (reset_done !== 1'b1 || rst_rx !== 1'b0 || reset_events !== 8'd2) begin
      n_fail++;
      $display("FAIL btn_release_run: got done=%b rx=%b ev=%0d, want 1 0 2", reset_done, rst_rx, reset_events);
    end
  endtask

  task automatic test_abort_rel_core();
    pll_locked = 1'b0;
    step(5);
    n_checks++;
    if (reset_events !== 8'd3) begin
      n_fail++;
      $display("FAIL rc_prep_events: got %0d, want 3", reset_events);
    end
    pll_locked = 1'b1;
    step(8);
    n_checks++;
    if (rst_core !== 1'b0 || rst_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL rc_in_rel_core: got core=%b tx=%b, want 0 1", rst_core, rst_tx);
    end
    // Abort lands on the same edge that would otherwise release tx.
    pll_locked = 1'b0;
    step(2);
    n_checks++;
    if (rst_core !== 1'b0 || rst_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL rc_before_abort: got core=%b tx=%b, want 0 1", rst_core, rst_tx);
    end
    step(1);
    n_checks++;
    if ({rst_core, rst_tx, rst_rx, reset_done} !== 4'b1110 || reset_events !== 8'd3) begin
      n_fail++;
      $display("FAIL rc_abort: got %b%b%b%b ev=%0d, want 1110 ev=3",
               rst_core, rst_tx, rst_rx, reset_done, reset_events);
    end
    step(2);
  endtask

  task automatic test_async_reset_rel_tx();
    pll_locked = 1'b1;
    step(2 + 2 * S + 1);
    n_checks++;
    if ({rst_core, rst_tx, rst_rx, reset_done} !== 4'b0010) begin
      n_fail++;
      $display("FAIL ar_in_rel_tx: got %b%b%b%b, want 0010", rst_core, rst_tx, rst_rx, reset_done);
    end
    #2;
    async_reset = 1'b1;
    #1;
    n_checks++;
    if ({rst_core, rst_tx, rst_rx, reset_done} !== 4'b1110 || reset_events !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got %b%b%b%b ev=%0d, want 1110 ev=0",
               rst_core, rst_tx, rst_rx, reset_done, reset_events);
    end
    #3;
    async_reset = 1'b0;
    step(2 + 3 * S + 4);
    n_checks++;
    if (reset_done !== 1'b1 || reset_events !== 8'd0) begin
      n_fail++;
      $display("FAIL ar_rerun: got done=%b ev=%0d, want 1 0", reset_done, reset_events);
    end
  endtask

  task automatic test_saturation();
    int exp_ev;
    for (int i = 0; i < 256; i++) begin
      pll_locked = 1'b0;
      step(3);
      exp_ev = (i + 1 > 255) ? 255 : i + 1;
      n_checks++;
      if (reset_events !== 8'(exp_ev) || rst_core !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_abort %0d: got ev=%0d core=%b, want ev=%0d core=1", i, reset_events, rst_core, exp_ev);
      end
      pll_locked = 1'b1;
      step(2 + 3 * S + 1);
      n_checks++;
      if (reset_done !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_rerun %0d: got done=%b, want 1", i, reset_done);
      end
    end
    n_checks++;
    if (reset_events !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_final: got %0d, want 255", reset_events);
    end
  endtask

  initial begin
    test_reset();
    test_release_sequence("release", 8'd0);
    test_lock_loss();
    test_button_bounce();
    test_abort_rel_core();
    test_async_reset_rel_tx();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
